// File: rtl/poci_key_irq_if.sv
// POCI peripheral bus: 12-bit decoded slot inside a 32-bit address, zero-wait slave.
interface poci;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport f (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/poci_key_irq.sv
// Key/switch debounce and event controller on a POCI slave port.
// Each raw input gets a synchroniser + debouncer lane; accepted edges latch W1C pending bits.
module poci_key_irq_deb #(
  parameter int   DEB_CYCLES = 50000,
  parameter logic RST_VAL    = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic upd_o,
  output logic nxt_o
);
  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

  logic [1:0]    sync_q;
  logic          d_q, d_d;
  logic [CW-1:0] c_q, c_d;
  logic          s;

  assign s = sync_q[1];

  // upd_o fires on the edge where d takes the new level, so events land together with LEVEL
  assign upd_o   = (s != d_q) && (c_q == CW'(DEB_CYCLES - 1));
  assign nxt_o   = s;
  assign level_o = d_q;

  always_comb begin
    c_d = '0;
    d_d = d_q;
    if (s != d_q) begin
      if (upd_o) d_d = s;
      else       c_d = c_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {2{RST_VAL}};
      d_q    <= RST_VAL;
      c_q    <= '0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      d_q    <= d_d;
      c_q    <= c_d;
    end
  end
endmodule

module poci_key_irq #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic       pclk,
  input  logic       presetn,
  poci.f             bus,
  input  logic [3:0] key,
  input  logic [9:0] sw,
  output logic       irq
);
  localparam int NUM_LANES = 14;
  localparam int NUM_KEYS  = 4;

  logic [NUM_LANES-1:0] raw, lvl, upd, nxt, ev;
  logic [NUM_KEYS-1:0]  kpress;
  logic [NUM_LANES-1:0] pend_q, pend_d, ien_q, ien_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [16:0]          cnt_sum;
  logic [2:0]           npress;
  logic                 irq_q;
  logic                 wr;
  logic [11:0]          addr;
  logic                 unused;

  assign raw = {sw, key};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    poci_key_irq_deb #(
      .DEB_CYCLES (DEB_CYCLES),
      .RST_VAL    (i < NUM_KEYS)
    ) u_deb (
      .clk     (pclk),
      .rst_n   (presetn),
      .raw_i   (raw[i]),
      .level_o (lvl[i]),
      .upd_o   (upd[i]),
      .nxt_o   (nxt[i])
    );
  end

  // keys are active-low: only a settle to 0 is a press
  assign kpress = upd[NUM_KEYS-1:0] & ~nxt[NUM_KEYS-1:0];
  assign ev     = {upd[NUM_LANES-1:NUM_KEYS], kpress};
  assign npress = 3'(kpress[0]) + 3'(kpress[1]) + 3'(kpress[2]) + 3'(kpress[3]);

  assign addr   = bus.paddr[11:0];
  assign wr     = bus.psel & bus.penable & bus.pwrite;
  assign unused = ^{bus.paddr[31:12], bus.pwdata[31:14]};

  assign cnt_sum = {1'b0, cnt_q} + 17'(npress);

  always_comb begin
    pend_d = pend_q;
    ien_d  = ien_q;
    cnt_d  = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    if (wr && addr == 12'h004) pend_d = pend_q & ~bus.pwdata[NUM_LANES-1:0];
    if (wr && addr == 12'h008) ien_d  = bus.pwdata[NUM_LANES-1:0];
    if (wr && addr == 12'h00C) cnt_d  = '0;
    // OR-in after the clear so a same-cycle event survives its W1C
    pend_d = pend_d | ev;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      pend_q <= '0;
      ien_q  <= '0;
      cnt_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ien_q  <= ien_d;
      cnt_q  <= cnt_d;
      irq_q  <= |(pend_q & ien_q);
    end
  end

  always_comb begin
    bus.prdata = '0;
    if (bus.psel && !bus.pwrite) begin
      case (addr)
        12'h000: bus.prdata = {18'b0, lvl};
        12'h004: bus.prdata = {18'b0, pend_q};
        12'h008: bus.prdata = {18'b0, ien_q};
        12'h00C: bus.prdata = {16'b0, cnt_q};
        default: bus.prdata = '0;
      endcase
    end
  end

  assign bus.pready  = 1'b1;
  assign bus.pslverr = 1'b0;
  assign irq         = irq_q;
endmodule

// File: tb/tb_poci_key_irq.sv
// Directed bench for poci_key_irq with DEB_CYCLES = 4; expectations are hand-derived cycle counts.
module tb_poci_key_irq;
  logic       pclk = 1'b0;
  logic       presetn;
  logic [3:0] key;
  logic [9:0] sw;
  logic       irq;
  int         checks = 0;
  int         errors = 0;

  poci bus ();

  poci_key_irq #(.DEB_CYCLES(4)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus),
    .key     (key),
    .sw      (sw),
    .irq     (irq)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    bus.paddr  = {20'b0, a};
    bus.pwrite = 1'b0;
    bus.psel   = 1'b1;
    #1;
    d        = bus.prdata;
    bus.psel = 1'b0;
  endtask

  task automatic chkreg(input string tag, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(tag, d, exp);
  endtask

  // call at a negedge; returns at the negedge after the committing posedge
  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    bus.paddr   = {20'b0, a};
    bus.pwdata  = d;
    bus.pwrite  = 1'b1;
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    @(negedge pclk);
    bus.penable = 1'b1;
    @(negedge pclk);
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
  endtask

  initial begin
    presetn     = 1'b0;
    key         = 4'hF;
    sw          = '0;
    bus.paddr   = '0;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.pwdata  = '0;
    repeat (2) @(negedge pclk);
    presetn = 1'b1;

    // reset state
    chkreg("rst_level", 12'h000, 32'h00F);
    chkreg("rst_pend",  12'h004, 32'h0);
    chkreg("rst_ien",   12'h008, 32'h0);
    chkreg("rst_evcnt", 12'h00C, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chkreg("bad_addr", 12'h010, 32'h0);
    chk("pready", {31'b0, bus.pready}, 32'h1);

    // key[0] press: d updates on the 6th edge, irq on the 7th
    @(negedge pclk);
    wr(12'h008, 32'h001);
    chkreg("ien_rb", 12'h008, 32'h001);
    @(negedge pclk);
    key = 4'hE;
    repeat (5) @(negedge pclk);
    chkreg("k0_level_5", 12'h000, 32'h00F);
    chkreg("k0_pend_5",  12'h004, 32'h0);
    @(negedge pclk);
    chkreg("k0_level_6", 12'h000, 32'h00E);
    chkreg("k0_pend_6",  12'h004, 32'h001);
    chk("k0_irq_6", {31'b0, irq}, 32'h0);
    @(negedge pclk);
    chk("k0_irq_7", {31'b0, irq}, 32'h1);
    chkreg("k0_evcnt", 12'h00C, 32'h1);

    // W1C clear; irq drops one cycle later
    @(negedge pclk);
    wr(12'h004, 32'h001);
    chkreg("clr_pend", 12'h004, 32'h0);
    chk("clr_irq_0", {31'b0, irq}, 32'h1);
    @(negedge pclk);
    chk("clr_irq_1", {31'b0, irq}, 32'h0);

    // 3-cycle glitch on key[1] is rejected
    key = 4'hC;
    repeat (3) @(negedge pclk);
    key = 4'hE;
    repeat (8) @(negedge pclk);
    chkreg("gl_level", 12'h000, 32'h00E);
    chkreg("gl_pend",  12'h004, 32'h0);
    chkreg("gl_evcnt", 12'h00C, 32'h1);
    chk("gl_irq", {31'b0, irq}, 32'h0);

    // sw[9] both directions, masked
    @(negedge pclk);
    wr(12'h008, 32'h0);
    sw[9] = 1'b1;
    repeat (8) @(negedge pclk);
    chkreg("sw_level_on", 12'h000, 32'h200E);
    chkreg("sw_pend_on",  12'h004, 32'h2000);
    @(negedge pclk);
    sw[9] = 1'b0;
    repeat (8) @(negedge pclk);
    chkreg("sw_level_off", 12'h000, 32'h00E);
    chkreg("sw_pend_off",  12'h004, 32'h2000);
    chk("sw_irq", {31'b0, irq}, 32'h0);
    @(negedge pclk);
    wr(12'h004, 32'h0);
    chkreg("w0_pend", 12'h004, 32'h2000);
    wr(12'h004, 32'h2000);
    chkreg("sw_clr", 12'h004, 32'h0);

    // release gives no event; W1C on the same edge as a new press loses
    wr(12'h008, 32'h001);
    key = 4'hF;
    repeat (8) @(negedge pclk);
    chkreg("rel_pend",  12'h004, 32'h0);
    chkreg("rel_level", 12'h000, 32'h00F);
    @(negedge pclk);
    key = 4'hE;
    repeat (4) @(negedge pclk);
    bus.paddr = 32'h004; bus.pwdata = 32'h001; bus.pwrite = 1'b1;
    bus.psel  = 1'b1;    bus.penable = 1'b0;
    @(negedge pclk);
    bus.penable = 1'b1;
    @(negedge pclk);
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    chkreg("race_pend",  12'h004, 32'h001);
    chkreg("race_level", 12'h000, 32'h00E);
    @(negedge pclk);
    chk("race_irq", {31'b0, irq}, 32'h1);
    chkreg("race_evcnt", 12'h00C, 32'h2);

    // saturation: two simultaneous presses from 0xFFFE
    force dut.cnt_q = 16'hFFFE;
    #1;
    release dut.cnt_q;
    chkreg("pre_evcnt", 12'h00C, 32'hFFFE);
    @(negedge pclk);
    key = 4'h2;
    repeat (8) @(negedge pclk);
    chkreg("sat2_evcnt", 12'h00C, 32'hFFFF);
    key = 4'hF;
    repeat (8) @(negedge pclk);
    key = 4'hD;
    repeat (8) @(negedge pclk);
    chkreg("sat1_evcnt", 12'h00C, 32'hFFFF);
    key = 4'hF;
    repeat (8) @(negedge pclk);

    // EVCNT write wins over a same-cycle press
    key = 4'hE;
    repeat (4) @(negedge pclk);
    bus.paddr = 32'h00C; bus.pwdata = 32'h0; bus.pwrite = 1'b1;
    bus.psel  = 1'b1;    bus.penable = 1'b0;
    @(negedge pclk);
    bus.penable = 1'b1;
    @(negedge pclk);
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    chkreg("wwin_evcnt", 12'h00C, 32'h0);

    // reset mid-debounce of sw[0]
    @(negedge pclk);
    sw[0] = 1'b1;
    repeat (3) @(negedge pclk);
    presetn = 1'b0;
    #1;
    chkreg("mr_level", 12'h000, 32'h00F);
    chkreg("mr_pend",  12'h004, 32'h0);
    chkreg("mr_ien",   12'h008, 32'h0);
    chkreg("mr_evcnt", 12'h00C, 32'h0);
    chk("mr_irq", {31'b0, irq}, 32'h0);
    @(negedge pclk);
    presetn = 1'b1;
    repeat (5) @(negedge pclk);
    chkreg("post_level_5", 12'h000, 32'h00F);
    @(negedge pclk);
    chkreg("post_level_6", 12'h000, 32'h01E);
    chkreg("post_pend_6",  12'h004, 32'h011);
    chkreg("post_evcnt",   12'h00C, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
